// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: instruction lengths, window size, queue FSM states.
package y86_pkg;

    localparam int unsigned MAX_ILEN   = 10;
    localparam int unsigned WORD_BYTES = 8;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_ERR   = 3'd3,
        S_DRAIN = 3'd4
    } fq_state_e;

    // Encoded length in bytes of an instruction given its icode.
    function automatic logic [3:0] ilen(input icode_e ic);
        case (ic)
            I_HALT, I_NOP, I_RET:              ilen = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:  ilen = 4'd2;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:      ilen = 4'd10;
            I_JXX, I_CALL:                     ilen = 4'd9;
            default:                           ilen = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/y86_ifetch_queue_byte_queue.sv
// Circular byte buffer: push up to 8 bytes, pop up to 10, head window always visible.
module byte_queue
    import y86_pkg::*;
#(
    parameter int unsigned QBYTES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic [3:0]                    push_len_i,
    input  logic [63:0]                   push_data_i,
    input  logic [3:0]                    pop_len_i,
    output logic [$clog2(QBYTES):0]       count_o,
    output logic [8*MAX_ILEN-1:0]         win_bytes_o,
    output logic [4:0]                    win_count_o
);

    localparam int unsigned AW = $clog2(QBYTES);
    localparam int unsigned PW = AW + 1;

    logic [7:0]    mem_q [QBYTES];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW-1:0] wr_addr [WORD_BYTES];
    logic [PW-1:0] rd_ptr;

    // Pointer advance; flush discards all queued bytes.
    always_comb begin
        head_d = head_q + PW'(pop_len_i);
        tail_d = tail_q + PW'(push_len_i);
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Slot addresses for the incoming bytes, wrapping around the buffer.
    always_comb begin
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            wr_addr[i] = AW'(tail_q + PW'(i));
        end
    end

    // Byte storage; unwritten slots are masked by the window logic.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (!flush_i && (4'(i) < push_len_i)) begin
                mem_q[wr_addr[i]] <= push_data_i[8*i +: 8];
            end
        end
    end

    assign count_o     = tail_q - head_q;
    assign win_count_o = (count_o >= PW'(MAX_ILEN)) ? 5'(MAX_ILEN) : 5'(count_o);

    // Head window; bytes beyond the occupancy read as zero.
    always_comb begin
        win_bytes_o = '0;
        rd_ptr      = '0;
        for (int i = 0; i < int'(MAX_ILEN); i++) begin
            rd_ptr = head_q + PW'(i);
            if (PW'(i) < count_o) begin
                win_bytes_o[8*i +: 8] = mem_q[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/y86_ifetch_queue.sv
// Instruction prefetch queue: aligned 8-byte fetches into a byte queue, 10-byte window at PC.
module y86_ifetch_queue
    import y86_pkg::*;
#(
    parameter int unsigned QBYTES   = 16,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [63:0]           redirect_pc,
    input  logic                  consume_valid,
    input  logic [3:0]            consume_len,
    output logic [8*MAX_ILEN-1:0] win_bytes,
    output logic [4:0]            win_count,
    output logic [63:0]           win_pc,
    output logic                  win_error,
    output logic                  mem_req_valid,
    output logic [63:0]           mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [63:0]           mem_rsp_data,
    input  logic                  mem_rsp_error
);

    localparam int unsigned PW = $clog2(QBYTES) + 1;
    localparam int unsigned CW = PW + 1;

    fq_state_e     state_q, state_d;
    logic [63:0]   fa_q, fa_d, pc_q, pc_d;
    logic [2:0]    skip_q, skip_d;
    logic          err_q, err_d, req_q;

    logic          flush;
    logic [3:0]    push_len, pop_len;
    logic [63:0]   push_data;
    logic [PW-1:0] q_count;
    logic          pop_ok, req_acc, room_after_word, room_now;
    logic [CW-1:0] used_after_pop;

    assign pop_ok  = consume_valid && (consume_len != 4'd0) && ({1'b0, consume_len} <= win_count);
    assign pop_len = (pop_ok && !redirect_valid) ? consume_len : 4'd0;
    assign req_acc = req_q && mem_req_ready;

    assign used_after_pop  = CW'(q_count) - CW'(pop_len);
    assign room_now        = used_after_pop <= CW'(QBYTES - WORD_BYTES);
    assign room_after_word = (used_after_pop + CW'(4'd8 - 4'(skip_q))) <= CW'(QBYTES - WORD_BYTES);
    assign push_data       = mem_rsp_data >> {skip_q, 3'b000};

    // Next-state, fetch address, PC and error tracking.
    always_comb begin
        state_d  = state_q;
        fa_d     = fa_q;
        skip_d   = skip_q;
        pc_d     = pc_q;
        err_d    = err_q;
        flush    = 1'b0;
        push_len = 4'd0;

        if (redirect_valid) begin
            flush  = 1'b1;
            err_d  = 1'b0;
            pc_d   = redirect_pc;
            fa_d   = redirect_pc;
            skip_d = redirect_pc[2:0];
            // Drain only if a response is still owed after this cycle.
            if ((state_q == S_REQ && req_acc) ||
                ((state_q == S_WAIT || state_q == S_DRAIN) && !mem_rsp_valid)) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            pc_d = pc_q + 64'(pop_len);
            case (state_q)
                S_REQ: begin
                    if (req_acc) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (mem_rsp_error) begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end else begin
                            push_len = 4'd8 - 4'(skip_q);
                            skip_d   = 3'd0;
                            fa_d     = {fa_q[63:3], 3'b000} + 64'd8;
                            state_d  = room_after_word ? S_REQ : S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (room_now) state_d = S_REQ;
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                S_DRAIN: begin
                    if (mem_rsp_valid) state_d = S_REQ;
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    // Control registers; request valid tracks the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            fa_q    <= RESET_PC;
            skip_q  <= RESET_PC[2:0];
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fa_q    <= fa_d;
            skip_q  <= skip_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            req_q   <= (state_d == S_REQ);
        end
    end

    byte_queue #(
        .QBYTES (QBYTES)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .push_len_i  (push_len),
        .push_data_i (push_data),
        .pop_len_i   (pop_len),
        .count_o     (q_count),
        .win_bytes_o (win_bytes),
        .win_count_o (win_count)
    );

    assign win_pc        = pc_q;
    assign win_error     = err_q;
    assign mem_req_valid = req_q;
    assign mem_req_addr  = {fa_q[63:3], 3'b000};

endmodule
